// File: rtl/fir_sm_fifo.sv
// Purpose: output-stream FIFO downstream of the FIR sm_* master, with a sample counter, done pulse and tlast/length check.
// Latency: a sample accepted at edge k appears on m_* after edge k (first-word fall-through), so 1 cycle when empty.
// Backpressure: s_tready drops only when the FIFO is full; it never depends on m_tready, so there is no pass-through when full.
//
// Ports:
//   axis_clk, axis_rst_n       clock, asynchronous active-low reset
//   ap_start, data_length      arm a transfer of data_length samples (ignored while busy)
//   s_tvalid/s_tdata/s_tlast   stream in from the FIR, s_tready back to it
//   m_tvalid/m_tdata/m_tlast   stream out to the host, m_tready from it
//   level                      occupancy 0..pDEPTH
//   out_cnt, busy, done        delivered-sample count, transfer armed, one-cycle completion pulse
//   tlast_err                  sticky tlast/length mismatch, cleared by an accepted ap_start
module fir_sm_fifo #(
    parameter int pDATA_WIDTH = 32,
    parameter int pDEPTH      = 8,
    parameter int pLW         = $clog2(pDEPTH) + 1
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   ap_start,
    input  logic [31:0]            data_length,
    input  logic                   s_tvalid,
    input  logic [pDATA_WIDTH-1:0] s_tdata,
    input  logic                   s_tlast,
    output logic                   s_tready,
    output logic                   m_tvalid,
    output logic [pDATA_WIDTH-1:0] m_tdata,
    output logic                   m_tlast,
    input  logic                   m_tready,
    output logic [pLW-1:0]         level,
    output logic [31:0]            out_cnt,
    output logic                   busy,
    output logic                   done,
    output logic                   tlast_err
);

    localparam int             AW   = $clog2(pDEPTH);
    localparam logic [pLW-1:0] FULL = pLW'(pDEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state;
    logic [pDATA_WIDTH:0] mem [pDEPTH];
    logic [AW-1:0]        wptr;
    logic [AW-1:0]        rptr;
    logic                 rdy_q;
    logic [31:0]          len_q;
    logic [31:0]          cnt_inc;
    logic                 push;
    logic                 pop;
    logic                 last_hit;

    // rdy_q keeps s_tready low during reset and for the first edge after release.
    assign s_tready          = rdy_q && (level != FULL);
    assign m_tvalid          = (level != '0);
    assign {m_tlast, m_tdata} = mem[rptr];
    assign push              = s_tvalid && s_tready;
    assign pop               = m_tvalid && m_tready;
    assign busy              = (state == RUN);
    assign cnt_inc           = out_cnt + 32'd1;
    assign last_hit          = (cnt_inc == len_q);

    // Storage needs no reset: an entry is only observable once level covers it.
    always_ff @(posedge axis_clk) begin
        if (push) begin
            mem[wptr] <= {s_tlast, s_tdata};
        end
    end

    // Pointers wrap naturally because pDEPTH is a power of two.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            rdy_q <= 1'b0;
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            rdy_q <= 1'b1;
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end
        end
    end

    // Transfer control. Pops in IDLE drain the FIFO but are neither counted nor checked.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state     <= IDLE;
            len_q     <= '0;
            out_cnt   <= '0;
            done      <= 1'b0;
            tlast_err <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (ap_start) begin
                    out_cnt   <= '0;
                    tlast_err <= 1'b0;
                    if (data_length != '0) begin
                        len_q <= data_length;
                        state <= RUN;
                    end else begin
                        // Zero-length transfer completes immediately without arming.
                        done <= 1'b1;
                    end
                end
            end else if (pop) begin
                out_cnt <= cnt_inc;
                // tlast must coincide exactly with the final counted sample.
                if (m_tlast != last_hit) begin
                    tlast_err <= 1'b1;
                end
                if (last_hit) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/fir_sm_fifo.md
Name: fir_sm_fifo

Overview:
- Output-stream buffer sitting directly downstream of the FIR core's sm_* AXI-Stream master; decouples the FIR pipeline from host back-pressure.
- Counts delivered samples against the programmed data length, produces a single-cycle done pulse for the ap_ctrl status logic, and flags tlast/length mismatches.
- AXI-Stream slave faces the FIR; AXI-Stream master faces the host/testbench.

Parameters:
- pDATA_WIDTH, 32, stream data width.
- pDEPTH, 8, FIFO depth in entries; power of 2, at least 2.
- pLW, $clog2(pDEPTH)+1, width of the level output (derived; do not override).

Ports:
- axis_clk  in  1  clock.
- axis_rst_n  in  1  reset.
- ap_start  in  1  one-cycle pulse; arms a new transfer.
- data_length  in  32  expected sample count; sampled on an accepted ap_start.
- s_tvalid  in  1  sample valid from FIR.
- s_tdata  in  pDATA_WIDTH  sample from FIR.
- s_tlast  in  1  last-sample marker from FIR.
- s_tready  out  1  FIFO can accept.
- m_tvalid  out  1  head entry valid.
- m_tdata  out  pDATA_WIDTH  head entry data.
- m_tlast  out  1  head entry tlast.
- m_tready  in  1  downstream accept.
- level  out  pLW  current occupancy, 0..pDEPTH.
- out_cnt  out  32  samples delivered since the last accepted ap_start.
- busy  out  1  transfer armed and not yet complete.
- done  out  1  one-cycle completion pulse.
- tlast_err  out  1  sticky mismatch flag.

Behaviour:
- Interface: reset axis_rst_n, asynchronous, active-low; clock axis_clk.
- Reset values: write/read pointers 0, level 0, out_cnt 0, busy 0, done 0, tlast_err 0, length register 0, rdy_q 0. FIFO contents are discarded. m_tvalid=0 and s_tready=0 while in reset.
- rdy_q sets to 1 on the first clock edge after reset release.
- s_tready = rdy_q && (level != pDEPTH). It must not depend on m_tready; there is no pass-through when the FIFO is full.
- Push: s_tvalid && s_tready at an edge writes {s_tlast, s_tdata} at wptr; wptr increments modulo pDEPTH.
- Pop:
  - m_tvalid = (level != 0).
  - m_tdata/m_tlast are the entry at rptr (first-word fall-through).
  - m_tvalid && m_tready at an edge advances rptr modulo pDEPTH.
- Latency: a sample pushed at edge k is visible on m_* after edge k (1 cycle when the FIFO was empty).
- Level update:
  - +1 on push only, -1 on pop only.
  - Unchanged on simultaneous push and pop, including at level pDEPTH-1 and at level 1.
  - At level pDEPTH only a pop can occur. At level 0 only a push can occur.
- m_tdata/m_tlast hold stable while m_tvalid=1 and m_tready=0.
- Transfer control (state IDLE/RUN, busy = RUN):
  - IDLE + ap_start, data_length != 0: load length register, clear out_cnt and tlast_err, go to RUN.
  - IDLE + ap_start, data_length == 0: clear out_cnt and tlast_err, stay in IDLE, done=1 on the next cycle.
  - RUN + ap_start: ignored; no counter or flag change.
  - RUN + pop handshake: out_cnt <= out_cnt+1. If out_cnt+1 == length, go to IDLE and done=1 in the following cycle only.
  - Pops while in IDLE still drain the FIFO but are not counted and never produce done.
- tlast_err, evaluated on each counted pop:
  - Set if m_tlast=1 and out_cnt+1 != length.
  - Set if m_tlast=0 and out_cnt+1 == length.
  - Sticky until the next accepted ap_start. The error does not block data flow or completion.
- out_cnt arithmetic is 32-bit unsigned, compared for equality only; it does not wrap within a legal transfer.
- Reset mid-transfer: returns immediately to the reset state. In-flight samples are lost and done is not produced.

Test Plan:
- Reset, then ap_start with data_length=5; FIR pushes 5 samples 1..5 (tlast on 5), m_tready=1 -> m_tdata 1..5 each 1 cycle after push, out_cnt=5, done high exactly 1 cycle, busy 1->0, tlast_err=0.
- pDEPTH=8, m_tready=0, push 10 samples -> s_tready falls after 8th accept, level=8, samples 9..10 stall; raise m_tready -> all 10 delivered in order, level returns to 0.
- Level 8 and continuous s_tvalid with m_tready toggling 1/0 -> simultaneous push/pop keeps level at 8 or 7, no loss or duplication over 32 samples.
- data_length=4, tlast asserted on sample 3 -> tlast_err=1 after sample 3, remains 1 after sample 4; done still pulses after sample 4; next ap_start clears tlast_err.
- data_length=0 ap_start -> done pulses the next cycle, busy stays 0; ap_start during RUN (length 6, 2 sent) -> ignored, done after 6th.
- Assert axis_rst_n low with level=3 mid-transfer -> m_tvalid=0, level=0, out_cnt=0, busy=0 immediately; s_tready=1 one cycle after release.
